// File: rtl/stack_sequencer_if.sv
`timescale 1ns/1ps
// Control-unit <-> stack sequencer bundle: request/op/data in, SP strobes and DONE/ERR/RDATA out.
// master = control unit and SP register side, slave = stack_sequencer.
interface stack_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 10
);
  logic              REQ;
  logic [1:0]        OP;
  logic [DATA_W-1:0] WDATA;
  logic [ADDR_W-1:0] SP_IN;
  logic              SP_LOAD;
  logic              SP_INCR;
  logic              SP_DECR;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [DATA_W-1:0] RDATA;
  logic [ADDR_W:0]   DEPTH;

  modport master (
    output REQ, OP, WDATA, SP_IN, SP_LOAD,
    input  SP_INCR, SP_DECR, BUSY, DONE, ERR, RDATA, DEPTH
  );

  modport slave (
    input  REQ, OP, WDATA, SP_IN, SP_LOAD,
    output SP_INCR, SP_DECR, BUSY, DONE, ERR, RDATA, DEPTH
  );
endinterface

// File: rtl/stack_sequencer.sv
`timescale 1ns/1ps
// Stack access engine: PUSH/POP/CALL/RET against a private stack RAM, strobing the external SP.
// Fixed 3-cycle op (accept, EXEC, RESP with DONE); REQ is ignored while BUSY and retried from IDLE.
module stack_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 10,
  parameter int MAX_DEPTH = 256
) (
  input logic              CLK,
  input logic              RST,
  stack_sequencer_if.slave bus
);
  localparam int BYTE_W = 8;
  localparam logic [ADDR_W:0]   DEPTH_MAX = (ADDR_W+1)'(MAX_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              wr_op_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W:0]   depth_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              req_wr;
  logic              acc_err;
  logic              exec_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr;

  // PUSH (00) and CALL (10) write the stack; bit 0 separates writers from readers.
  assign req_wr  = ~bus.OP[0];
  assign acc_err = req_wr ? (depth_q == DEPTH_MAX) : (depth_q == '0);
  assign exec_ok = (state == EXEC) && !err_q && !RST;
  assign mem_we  = exec_ok && wr_op_q;
  assign waddr   = bus.SP_IN - ADDR_ONE;

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[waddr] <= wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      wr_op_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      depth_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            wr_op_q <= req_wr;
            err_q   <= acc_err;
            wdata_q <= bus.WDATA;
            if (bus.OP == 2'b00)
              wdata_q <= {{(DATA_W-BYTE_W){1'b0}}, bus.WDATA[BYTE_W-1:0]};
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!wr_op_q)
            rdata_q <= err_q ? '0 : mem[bus.SP_IN];
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // A direct SP load invalidates occupancy, overriding this cycle's EXEC update.
      if (bus.SP_LOAD)
        depth_q <= '0;
      else if (state == EXEC && !err_q)
        depth_q <= wr_op_q ? depth_q + DEPTH_ONE : depth_q - DEPTH_ONE;
    end
  end

  assign bus.SP_DECR = mem_we;
  assign bus.SP_INCR = exec_ok && !wr_op_q;
  assign bus.BUSY    = (state != IDLE);
  assign bus.DONE    = (state == RESP) && !RST;
  assign bus.ERR     = bus.DONE && err_q;
  assign bus.RDATA   = rdata_q;
  assign bus.DEPTH   = depth_q;
endmodule

// File: tb/tb_stack_sequencer.sv
`timescale 1ns/1ps
// Bench for stack_sequencer: models the SP register and a reference stack; expectations go
// through a scoreboard queue and are compared when DONE appears.
module tb_stack_sequencer;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  stack_sequencer_if #(.ADDR_W(8), .DATA_W(10)) bus ();
  stack_sequencer #(.ADDR_W(8), .DATA_W(10), .MAX_DEPTH(256)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  // Stack pointer register owned by the bench.
  logic [7:0] sp;
  logic       sp_force;
  logic [7:0] sp_force_val;
  logic [7:0] sp_load_val;
  assign bus.SP_IN = sp;
  always @(posedge CLK) begin
    if (sp_force)         sp <= sp_force_val;
    else if (bus.SP_LOAD) sp <= sp_load_val;
    else if (bus.SP_INCR) sp <= sp + 8'd1;
    else if (bus.SP_DECR) sp <= sp - 8'd1;
  end

  typedef struct packed {
    logic       err;
    logic [9:0] rdata;
    logic [8:0] depth;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] mstk[$];
  int         mdepth;
  logic [9:0] m_rdata;
  int         n_chk;
  int         n_fail;

  int         done_cnt, incr_cnt, decr_cnt;
  logic       incr1, decr1, busy1, o_err;
  logic [9:0] o_rdata;
  logic [8:0] o_depth, depth_end;

  task automatic model_op(input logic [1:0] op, input logic [9:0] wd);
    exp_t e;
    if (!op[0]) begin
      if (mdepth == 256) e.err = 1'b1;
      else begin
        e.err = 1'b0;
        mstk.push_back(op == 2'b00 ? {2'b00, wd[7:0]} : wd);
        mdepth++;
      end
    end else begin
      if (mdepth == 0) begin
        e.err   = 1'b1;
        m_rdata = '0;
      end else begin
        e.err   = 1'b0;
        m_rdata = mstk.pop_back();
        mdepth--;
      end
    end
    e.rdata = m_rdata;
    e.depth = 9'(mdepth);
    sb.push_back(e);
  endtask

  // Issue one request and observe a fixed 3-cycle window after acceptance.
  task automatic run_op(input logic [1:0] op, input logic [9:0] wd, input bit load_exec, input bit rst_exec);
    bus.REQ = 1'b1; bus.OP = op; bus.WDATA = wd;
    done_cnt = 0; incr_cnt = 0; decr_cnt = 0;
    o_err = 1'bx; o_rdata = 'x; o_depth = 'x;
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK); #1;
      bus.REQ     = 1'b0;
      bus.SP_LOAD = load_exec && (c == 1);
      RST         = rst_exec && (c == 1);
      #1;
      if (bus.SP_INCR) incr_cnt++;
      if (bus.SP_DECR) decr_cnt++;
      if (c == 1) begin
        incr1 = bus.SP_INCR; decr1 = bus.SP_DECR; busy1 = bus.BUSY;
      end
      if (bus.DONE) begin
        done_cnt++;
        o_err = bus.ERR; o_rdata = bus.RDATA; o_depth = bus.DEPTH;
      end
      if (c == 3) depth_end = bus.DEPTH;
    end
  endtask

  task automatic set_sp(input logic [7:0] v, input bit with_load);
    if (with_load) begin
      sp_load_val = v; bus.SP_LOAD = 1'b1;
      mstk.delete(); mdepth = 0;
    end else begin
      sp_force_val = v; sp_force = 1'b1;
    end
    @(posedge CLK); #1;
    bus.SP_LOAD = 1'b0; sp_force = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.REQ = 1'b1; bus.OP = 2'b00; bus.WDATA = 10'h3FF; bus.SP_LOAD = 1'b0;
    sp_force = 1'b1; sp_force_val = 8'h00; sp_load_val = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0 || bus.SP_INCR !== 1'b0 || bus.SP_DECR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b incr=%b decr=%b, required all 0",
               bus.BUSY, bus.DONE, bus.ERR, bus.SP_INCR, bus.SP_DECR);
    end
    n_chk++;
    if (bus.DEPTH !== 9'd0 || bus.RDATA !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_data: depth=%0d rdata=%h, required 0 and 000", bus.DEPTH, bus.RDATA);
    end
    RST = 1'b0; bus.REQ = 1'b0; sp_force = 1'b0;
    @(posedge CLK); #1;
    n_chk++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_dropped: busy=%b, required 0", bus.BUSY);
    end
  endtask

  task automatic test_push_pop();
    exp_t e;
    model_op(2'b00, 10'h3A5);
    run_op(2'b00, 10'h3A5, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (done_cnt !== 1 || o_err !== e.err || o_depth !== e.depth) begin
      n_fail++;
      $display("FAIL push_done: done=%0d err=%b depth=%0d, required done=1 err=%b depth=%0d",
               done_cnt, o_err, o_depth, e.err, e.depth);
    end
    n_chk++;
    if (decr1 !== 1'b1 || decr_cnt !== 1 || incr_cnt !== 0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL push_strobe: decr_exec=%b decr=%0d incr=%0d busy=%b, required 1 1 0 1",
               decr1, decr_cnt, incr_cnt, busy1);
    end
    n_chk++;
    if (sp !== 8'hFF) begin
      n_fail++;
      $display("FAIL push_sp: sp=%h, required ff", sp);
    end
    model_op(2'b01, 10'h000);
    run_op(2'b01, 10'h000, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (done_cnt !== 1 || o_err !== e.err || o_rdata !== e.rdata || o_depth !== e.depth) begin
      n_fail++;
      $display("FAIL pop_done: done=%0d err=%b rdata=%h depth=%0d, required 1 %b %h %0d",
               done_cnt, o_err, o_rdata, o_depth, e.err, e.rdata, e.depth);
    end
    n_chk++;
    if (incr1 !== 1'b1 || incr_cnt !== 1 || decr_cnt !== 0 || sp !== 8'h00) begin
      n_fail++;
      $display("FAIL pop_strobe: incr_exec=%b incr=%0d decr=%0d sp=%h, required 1 1 0 00",
               incr1, incr_cnt, decr_cnt, sp);
    end
  endtask

  task automatic test_call_ret();
    logic [1:0] ops [4]    = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic [9:0] wds [4]    = '{10'h123, 10'h2FE, 10'h000, 10'h000};
    logic [7:0] sp_exp [4] = '{8'h7F, 8'h7E, 8'h7F, 8'h80};
    exp_t e;
    set_sp(8'h80, 1'b1);
    for (int i = 0; i < 4; i++) begin
      model_op(ops[i], wds[i]);
      run_op(ops[i], wds[i], 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (done_cnt !== 1 || o_err !== e.err || o_rdata !== e.rdata || o_depth !== e.depth || sp !== sp_exp[i]) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: done=%0d err=%b rdata=%h depth=%0d sp=%h, required 1 %b %h %0d %h",
                 i, done_cnt, o_err, o_rdata, o_depth, sp, e.err, e.rdata, e.depth, sp_exp[i]);
      end
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    logic [7:0] sp0;
    for (int i = 0; i < 2; i++) begin
      sp0 = sp;
      model_op(i == 0 ? 2'b01 : 2'b11, 10'h000);
      run_op(i == 0 ? 2'b01 : 2'b11, 10'h000, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (done_cnt !== 1 || o_err !== 1'b1 || o_err !== e.err || o_rdata !== e.rdata || o_depth !== e.depth) begin
        n_fail++;
        $display("FAIL underflow[%0d]: done=%0d err=%b rdata=%h depth=%0d, required 1 1 %h %0d",
                 i, done_cnt, o_err, o_rdata, o_depth, e.rdata, e.depth);
      end
      n_chk++;
      if (incr_cnt !== 0 || decr_cnt !== 0 || sp !== sp0) begin
        n_fail++;
        $display("FAIL underflow_strobe[%0d]: incr=%0d decr=%0d sp=%h, required 0 0 %h",
                 i, incr_cnt, decr_cnt, sp, sp0);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [9:0] wd;
    set_sp(8'h00, 1'b1);
    for (int i = 0; i < 257; i++) begin
      wd = {2'(i) ^ 2'b10, 8'(i * 7 + 3)};
      model_op(2'b00, wd);
      run_op(2'b00, wd, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (done_cnt !== 1 || o_err !== e.err || o_depth !== e.depth || decr_cnt !== (e.err ? 0 : 1)) begin
        n_fail++;
        $display("FAIL overflow_push[%0d]: done=%0d err=%b depth=%0d decr=%0d, required 1 %b %0d %0d",
                 i, done_cnt, o_err, o_depth, decr_cnt, e.err, e.depth, e.err ? 0 : 1);
      end
    end
    // Draining all 256 also reads back address 0xFF, which the refused push must not touch.
    for (int i = 0; i < 257; i++) begin
      model_op(2'b01, 10'h000);
      run_op(2'b01, 10'h000, 1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++;
      if (done_cnt !== 1 || o_err !== e.err || o_rdata !== e.rdata || o_depth !== e.depth) begin
        n_fail++;
        $display("FAIL overflow_pop[%0d]: done=%0d err=%b rdata=%h depth=%0d, required 1 %b %h %0d",
                 i, done_cnt, o_err, o_rdata, o_depth, e.err, e.rdata, e.depth);
      end
    end
  endtask

  task automatic test_sp_load();
    exp_t e;
    set_sp(8'h40, 1'b1);
    for (int i = 0; i < 5; i++) begin
      model_op(2'b00, 10'(8'h10 + i));
      run_op(2'b00, 10'(8'h10 + i), 1'b0, 1'b0);
      e = sb.pop_front();
    end
    n_chk++;
    if (o_depth !== 9'd5 || o_depth !== e.depth) begin
      n_fail++;
      $display("FAIL load_setup: depth=%0d, required 5", o_depth);
    end
    sp_load_val = 8'h40;
    run_op(2'b00, 10'h0C7, 1'b1, 1'b0);
    mstk.delete(); mdepth = 0;
    n_chk++;
    if (done_cnt !== 1 || o_err !== 1'b0 || o_depth !== 9'd0 || decr_cnt !== 1 || sp !== 8'h40) begin
      n_fail++;
      $display("FAIL load_in_exec: done=%0d err=%b depth=%0d decr=%0d sp=%h, required 1 0 0 1 40",
               done_cnt, o_err, o_depth, decr_cnt, sp);
    end
    // The in-flight push still wrote 0xC7 at 0x3A; stage depth elsewhere and read it back.
    set_sp(8'h90, 1'b0);
    model_op(2'b00, 10'h011);
    run_op(2'b00, 10'h011, 1'b0, 1'b0);
    e = sb.pop_front();
    set_sp(8'h3A, 1'b0);
    run_op(2'b01, 10'h000, 1'b0, 1'b0);
    mstk.delete(); mdepth = 0; m_rdata = 10'h0C7;
    n_chk++;
    if (done_cnt !== 1 || o_err !== 1'b0 || o_rdata !== 10'h0C7 || o_depth !== 9'd0) begin
      n_fail++;
      $display("FAIL load_write_kept: done=%0d err=%b rdata=%h depth=%0d, required 1 0 0c7 0",
               done_cnt, o_err, o_rdata, o_depth);
    end
  endtask

  task automatic test_rst_abort();
    exp_t e;
    set_sp(8'h30, 1'b1);
    model_op(2'b00, 10'h055);
    run_op(2'b00, 10'h055, 1'b0, 1'b0);
    e = sb.pop_front();
    model_op(2'b01, 10'h000);
    run_op(2'b01, 10'h000, 1'b0, 1'b0);
    e = sb.pop_front();
    n_chk++;
    if (o_rdata !== e.rdata || sp !== 8'h30) begin
      n_fail++;
      $display("FAIL abort_setup: rdata=%h sp=%h, required %h 30", o_rdata, sp, e.rdata);
    end
    run_op(2'b00, 10'h0AA, 1'b0, 1'b1);
    m_rdata = '0; mstk.delete(); mdepth = 0;
    n_chk++;
    if (decr1 !== 1'b0 || decr_cnt !== 0 || done_cnt !== 0 || depth_end !== 9'd0 || sp !== 8'h30) begin
      n_fail++;
      $display("FAIL abort: decr_exec=%b decr=%0d done=%0d depth=%0d sp=%h, required 0 0 0 0 30",
               decr1, decr_cnt, done_cnt, depth_end, sp);
    end
    // Address 0x2F must still hold 0x055: stage depth at another address, then read 0x2F.
    set_sp(8'h70, 1'b0);
    model_op(2'b00, 10'h011);
    run_op(2'b00, 10'h011, 1'b0, 1'b0);
    e = sb.pop_front();
    set_sp(8'h2F, 1'b0);
    run_op(2'b01, 10'h000, 1'b0, 1'b0);
    mstk.delete(); mdepth = 0; m_rdata = 10'h055;
    n_chk++;
    if (done_cnt !== 1 || o_err !== 1'b0 || o_rdata !== 10'h055 || o_depth !== 9'd0) begin
      n_fail++;
      $display("FAIL abort_no_write: done=%0d err=%b rdata=%h depth=%0d, required 1 0 055 0",
               done_cnt, o_err, o_rdata, o_depth);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   done_at [$];
    model_op(2'b00, 10'h021);
    model_op(2'b00, 10'h042);
    bus.REQ = 1'b1; bus.OP = 2'b00; bus.WDATA = 10'h021;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (c == 3) bus.WDATA = 10'h042;
      if (c == 6) bus.REQ = 1'b0;
      #1;
      if (bus.DONE) done_at.push_back(c);
    end
    void'(sb.pop_front());
    e = sb.pop_front();
    n_chk++;
    if (done_at.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d, required 2", done_at.size());
    end else begin
      n_chk++;
      if (done_at[0] !== 2 || done_at[1] !== 5) begin
        n_fail++;
        $display("FAIL b2b_spacing: done cycles %0d,%0d, required 2,5", done_at[0], done_at[1]);
      end
    end
    n_chk++;
    if (bus.DEPTH !== e.depth || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_depth: depth=%0d busy=%b, required %0d 0", bus.DEPTH, bus.BUSY, e.depth);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; mdepth = 0; m_rdata = '0;
    sp_force = 1'b0; sp_force_val = '0; sp_load_val = '0;
    bus.REQ = 1'b0; bus.OP = 2'b00; bus.WDATA = '0; bus.SP_LOAD = 1'b0;
    RST = 1'b1;
    test_reset();
    test_push_pop();
    test_call_ret();
    test_underflow();
    test_overflow();
    test_sp_load();
    test_rst_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
